// File: rtl/rand_range_pkg.sv
// rand_range_pkg
// Shared definitions for the bounded-random consumer of the prng8 generator:
//   - rr_state_e  : reseed sequencer states (IDLE, REQ, FLUSH)
//   - RESEED_HOLD : cycles the reseed request stays asserted
//   - FLUSH_CYC   : cycles with sampling blocked after a reseed request
//   - width_of()  : result width for a given range size, never below 1 bit
//   - thresh_of() : rejection threshold, largest multiple of LIMIT <= 256
package rand_range_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } rr_state_e;

    localparam int RESEED_HOLD = 2;
    localparam int FLUSH_CYC   = 2;

    // LIMIT=1 needs no bits of information but still gets a 1-bit port.
    function automatic int width_of(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

    // Samples at or above this value would bias the modulo result and are
    // discarded. 9 bits so that LIMIT=256 (and powers of two) yield 256,
    // which no 8-bit sample can reach.
    function automatic logic [8:0] thresh_of(input int limit);
        int t;
        t = 256 - (256 % limit);
        return 9'(t);
    endfunction

endpackage

// File: rtl/rand_range_fifo.sv
// rand_range_fifo
// Parametric synchronous FIFO with a registered head word.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored when full unless popping too)
//   push_data  : WIDTH-bit entry to append
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry; holds the last popped value when empty
//   count      : occupancy, 0..DEPTH
// Simultaneous push and pop leaves the occupancy unchanged.
module rand_range_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        rd_next  = rd_ptr_q + 1'b1;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_next         : rd_ptr_q;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end

        // The head register mirrors mem[rd_ptr] whenever the FIFO is
        // non-empty. The pushed word bypasses memory when it becomes the
        // head in the same cycle it is written.
        head_d = head_q;
        if (do_pop && (count_q > CW'(1))) begin
            head_d = mem[rd_next];
        end else if (do_push && ((count_q == '0) || (do_pop && (count_q == CW'(1))))) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/rand_range.sv
// rand_range
// Turns the 8-bit prng8 stream into uniform values in [0, LIMIT-1] by
// rejection sampling, and buffers them in a FIFO behind valid/ready.
//   clk, rst   : clock, synchronous active-high reset
//   en         : sampling enable
//   rand_in    : prng8 output, fresh every cycle
//   out_data   : FIFO head (holds last value when empty)
//   out_valid  : FIFO non-empty
//   out_ready  : consumer accepts out_data when out_valid && out_ready
//   count      : FIFO occupancy
//   rejects    : saturating count of discarded samples
//   reseed     : reseed request to prng8
//   seed       : seed value for prng8, stable while reseed is high
// Optional feature macro: RAND_RANGE_RESEED_EN. When defined, a sequencer
// requests a prng8 reseed every RESEED_CNT accepted samples and blocks
// sampling until the reloaded generator is producing fresh values. When
// undefined, reseed and seed are tied low.
import rand_range_pkg::*;

module rand_range #(
    parameter  int LIMIT      = 6,
    parameter  int FIFO_DEPTH = 4,
    parameter  int RESEED_CNT = 64,
    localparam int W          = width_of(LIMIT),
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [7:0]    rand_in,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic [15:0]   rejects,
    output logic          reseed,
    output logic [7:0]    seed
);

    localparam logic [8:0] THRESH = thresh_of(LIMIT);
    localparam logic [8:0] LIMIT9 = 9'(LIMIT);

    logic [7:0]    s_data_q, s_data_d;
    logic          s_vld_q, s_vld_d;
    logic [15:0]   rejects_q, rejects_d;
    logic          accept;
    logic          room;
    logic          can_capture;
    logic [W-1:0]  push_data;
    logic [CW-1:0] fifo_count;

    // Stage-2 decision on the captured sample.
    assign accept    = s_vld_q && ({1'b0, s_data_q} < THRESH);
    assign push_data = W'({1'b0, s_data_q} % LIMIT9);

    // Reserve a slot for the in-flight sample as if it will be accepted;
    // pops are not credited, so the stage can never overflow the FIFO.
    assign room = ({1'b0, fifo_count} + {{CW{1'b0}}, s_vld_q}) < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        s_data_d  = s_data_q;
        s_vld_d   = 1'b0;
        rejects_d = rejects_q;
        if (en && room && can_capture) begin
            s_data_d = rand_in;
            s_vld_d  = 1'b1;
        end
        if (s_vld_q && !accept && (rejects_q != 16'hFFFF)) begin
            rejects_d = rejects_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_data_q  <= '0;
            s_vld_q   <= 1'b0;
            rejects_q <= '0;
        end else begin
            s_data_q  <= s_data_d;
            s_vld_q   <= s_vld_d;
            rejects_q <= rejects_d;
        end
    end

    rand_range_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_data),
        .pop       (out_ready),
        .head      (out_data),
        .count     (fifo_count)
    );

    assign count     = fifo_count;
    assign out_valid = (fifo_count != '0);
    assign rejects   = rejects_q;

`ifdef RAND_RANGE_RESEED_EN
    // Extra bit of headroom: one in-flight sample may still be accepted
    // after the counter was cleared on entry to REQ.
    localparam int ACW = $clog2(RESEED_CNT + 1) + 1;

    rr_state_e      state_q, state_d;
    logic [ACW-1:0] acc_cnt_q, acc_cnt_d;
    logic [ACW-1:0] acc_base;
    logic [7:0]     seed_acc_q, seed_acc_d;
    logic [7:0]     seed_acc_base;
    logic [7:0]     seed_q, seed_d;
    logic [1:0]     phase_q, phase_d;
    logic           reached;
    logic           reload;

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        phase_d = phase_q;
        reached = (acc_cnt_q >= ACW'(RESEED_CNT));
        reload  = 1'b0;

        case (state_q)
            IDLE: begin
                if (reached) begin
                    reload  = 1'b1;
                    seed_d  = seed_acc_q ^ 8'hA5;
                    phase_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (phase_q == 2'(RESEED_HOLD - 1)) begin
                    phase_d = '0;
                    state_d = FLUSH;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            FLUSH: begin
                if (phase_q == 2'(FLUSH_CYC - 1)) begin
                    phase_d = '0;
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            default: begin
                phase_d = '0;
                state_d = IDLE;
            end
        endcase

        // Accumulators restart from the reload point; a push in the same
        // cycle belongs to the next reseed period.
        acc_base      = reload ? '0 : acc_cnt_q;
        seed_acc_base = reload ? 8'h00 : seed_acc_q;
        acc_cnt_d     = accept ? acc_base + 1'b1 : acc_base;
        seed_acc_d    = accept ? seed_acc_base ^ s_data_q : seed_acc_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_cnt_q  <= '0;
            seed_acc_q <= '0;
            seed_q     <= '0;
            phase_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            seed_acc_q <= seed_acc_d;
            seed_q     <= seed_d;
            phase_q    <= phase_d;
        end
    end

    assign can_capture = (state_q == IDLE);
    assign reseed      = (state_q == REQ);
    assign seed        = seed_q;
`else
    assign can_capture = 1'b1;
    assign reseed      = 1'b0;
    assign seed        = 8'h00;
`endif

endmodule

// File: tb/tb_rand_range.sv
// tb_rand_range
// Directed bench for rand_range: LIMIT=6 (main), LIMIT=256 and LIMIT=1
// instances share the stimulus. Reseed checks follow RAND_RANGE_RESEED_EN.
module tb_rand_range;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       out_ready;
    logic [7:0] rand_in;

    logic [2:0]  a_data;
    logic        a_valid;
    logic [2:0]  a_count;
    logic [15:0] a_rejects;
    logic        a_reseed;
    logic [7:0]  a_seed;

    logic [7:0]  b_data;
    logic        b_valid;
    logic [2:0]  b_count;
    logic [15:0] b_rejects;
    logic        b_reseed;
    logic [7:0]  b_seed;

    logic [0:0]  c_data;
    logic        c_valid;
    logic [2:0]  c_count;
    logic [15:0] c_rejects;
    logic        c_reseed;
    logic [7:0]  c_seed;

    int n_eval = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rand_range #(.LIMIT(6), .FIFO_DEPTH(4), .RESEED_CNT(4)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .rand_in(rand_in),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
        .count(a_count), .rejects(a_rejects), .reseed(a_reseed), .seed(a_seed)
    );

    rand_range #(.LIMIT(256), .FIFO_DEPTH(4), .RESEED_CNT(64)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .rand_in(rand_in),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
        .count(b_count), .rejects(b_rejects), .reseed(b_reseed), .seed(b_seed)
    );

    rand_range #(.LIMIT(1), .FIFO_DEPTH(4), .RESEED_CNT(64)) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .rand_in(rand_in),
        .out_data(c_data), .out_valid(c_valid), .out_ready(out_ready),
        .count(c_count), .rejects(c_rejects), .reseed(c_reseed), .seed(c_seed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] t1_in [6];
        logic [7:0] t6_in [12];
        t1_in = '{8'h0D, 8'hFB, 8'hFC, 8'hFF, 8'h00, 8'h00};
        t6_in = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                  8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h31};

        rst = 1'b1; en = 1'b0; out_ready = 1'b0; rand_in = 8'h00;
        tick(); tick();

        // Reset state
        chk("rst_valid",   a_valid,   0);
        chk("rst_data",    a_data,    0);
        chk("rst_count",   a_count,   0);
        chk("rst_rejects", a_rejects, 0);
        chk("rst_reseed",  a_reseed,  0);
        chk("rst_seed",    a_seed,    0);
        $display("reset: valid=%0d data=%0d count=%0d", a_valid, a_data, a_count);

        // Test 1: LIMIT=6 mapping and rejection, out_ready=1
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        rand_in = t1_in[0]; tick();
        chk("t1_lat_valid", a_valid, 0);
        rand_in = t1_in[1]; tick();
        chk("t1_v0_valid", a_valid, 1);
        chk("t1_v0_data",  a_data,  1);
        $display("t1: in=0x0D out=%0d", a_data);
        rand_in = t1_in[2]; tick();
        chk("t1_v1_data",  a_data,  5);
        $display("t1: in=0xFB out=%0d", a_data);
        rand_in = t1_in[3]; tick();
        chk("t1_empty",    a_valid, 0);
        chk("t1_hold",     a_data,  5);
        chk("t1_rej1",     a_rejects, 1);
        rand_in = t1_in[4]; tick();
        chk("t1_rej2",     a_rejects, 2);
        en = 1'b0; rand_in = t1_in[5]; tick();
        chk("t1_v2_valid", a_valid, 1);
        chk("t1_v2_data",  a_data,  0);
        chk("t1_rejects",  a_rejects, 2);
        $display("t1: in=0x00 out=%0d rejects=%0d", a_data, a_rejects);

        // Test 2: backpressure, FIFO fills to 4 and drains in order
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_in = 8'(16 + 17 * i);
            tick();
        end
        chk("t2_full_count", a_count, 4);
        chk("t2_rejects",    a_rejects, 0);
        en = 1'b0; out_ready = 1'b1;
        chk("t2_pop0", a_data, 4);
        $display("t2: pop out=%0d", a_data);
        tick();
        chk("t2_pop1", a_data, 3);
        chk("t2_cnt3", a_count, 3);
        $display("t2: pop out=%0d", a_data);
        tick();
        chk("t2_pop2", a_data, 2);
        $display("t2: pop out=%0d", a_data);
        tick();
        chk("t2_pop3", a_data, 1);
        chk("t2_cnt1", a_count, 1);
        $display("t2: pop out=%0d", a_data);
        tick();
        chk("t2_drained", a_count, 0);
        chk("t2_novalid", a_valid, 0);

        // Test 4: reset mid-operation with count=3 and stage loaded
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; out_ready = 1'b0;
        rand_in = 8'hFF; tick();
        rand_in = 8'h10; tick();
        rand_in = 8'h11; tick();
        rand_in = 8'h12; tick();
        rand_in = 8'h13; tick();
        chk("t4_pre_count", a_count, 3);
        chk("t4_pre_rej",   a_rejects, 1);
        rst = 1'b1; tick();
        chk("t4_count",   a_count,   0);
        chk("t4_valid",   a_valid,   0);
        chk("t4_rejects", a_rejects, 0);
        chk("t4_data",    a_data,    0);
        rst = 1'b0; en = 1'b0; tick();
        chk("t4_stage_lost", a_count, 0);
        $display("t4: after reset count=%0d valid=%0d", a_count, a_valid);

        // Test 3: LIMIT=256 passes samples through with 2-cycle latency;
        // LIMIT=1 always yields 0
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rand_in = 8'(i);
            tick();
            if (i >= 1) begin
                chk("t3_data",  b_data, 32'(i - 1));
                chk("t3_count", b_count, 1);
                chk("t3_lim1",  c_data, 0);
            end else begin
                chk("t3_first_valid", b_valid, 0);
            end
        end
        chk("t3_rejects",      b_rejects, 0);
        chk("t3_lim1_valid",   c_valid,   1);
        chk("t3_lim1_rejects", c_rejects, 0);
        $display("t3: last out=0x%0h rejects=%0d", b_data, b_rejects);

        // Test 5: constant reject stream saturates the counter
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; out_ready = 1'b1; rand_in = 8'hFF;
        for (int i = 0; i < 1000; i++) tick();
        chk("t5_rej999", a_rejects, 999);
        for (int i = 0; i < 65000; i++) tick();
        chk("t5_sat",     a_rejects, 16'hFFFF);
        chk("t5_count",   a_count,   0);
        chk("t5_novalid", a_valid,   0);
        $display("t5: rejects=0x%0h", a_rejects);

        // Test 6: reseed sequence (RESEED_CNT=4)
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; out_ready = 1'b1;
`ifdef RAND_RANGE_RESEED_EN
        for (int i = 0; i < 5; i++) begin
            rand_in = t6_in[i];
            tick();
        end
        chk("t6_pre_reseed", a_reseed, 0);
        rand_in = t6_in[5]; tick();
        chk("t6_req1",   a_reseed, 1);
        chk("t6_seed1",  a_seed,   8'hAA);
        rand_in = t6_in[6]; tick();
        chk("t6_req2",   a_reseed, 1);
        chk("t6_seed2",  a_seed,   8'hAA);
        chk("t6_lastpush", a_valid, 1);
        rand_in = t6_in[7]; tick();
        chk("t6_req_end", a_reseed, 0);
        chk("t6_blk8",    a_valid,  0);
        rand_in = t6_in[8]; tick();
        chk("t6_blk9",    a_valid,  0);
        rand_in = t6_in[9]; tick();
        chk("t6_blk10",   a_valid,  0);
        rand_in = t6_in[10]; tick();
        chk("t6_blk11",   a_valid,  0);
        rand_in = t6_in[11]; tick();
        chk("t6_resume_valid", a_valid, 1);
        chk("t6_resume_data",  a_data,  1);
        $display("t6: seed=0x%0h resumed out=%0d", a_seed, a_data);
`else
        for (int i = 0; i < 12; i++) begin
            rand_in = t6_in[i];
            tick();
            chk("t6_reseed_off", a_reseed, 0);
            chk("t6_seed_off",   a_seed,   0);
        end
        chk("t6_flow_valid", a_valid, 1);
        $display("t6: reseed disabled, reseed=%0d seed=0x%0h", a_reseed, a_seed);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
